cpu_regfile_sched: RTL



---
 rtl/cpu_regfile_sched_pkg.sv | 27 ++
 rtl/cpu_regfile_sched_scoreboard.sv | 53 +++++
 rtl/cpu_regfile_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cpu_regfile_sched_pkg.sv
// Shared constants and types for the moxie register-file write/read scheduler.
package cpu_regfile_sched_pkg;

   localparam int NUM_REGS = 16;
   localparam int IDX_W    = $clog2(NUM_REGS);
   localparam int DATA_W   = 32;
   localparam int REG_FP   = 0;
   localparam int REG_SP   = 1;

   // Debug-write wait cycles before debug overrides load priority.
   localparam logic [1:0] STARVE_LIMIT = 2'd3;

   typedef enum logic [1:0] {
      WSEL_NONE = 2'd0,
      WSEL_WB   = 2'd1,
      WSEL_LD   = 2'd2,
      WSEL_DBG  = 2'd3
   } wsel_e;

   function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REGS-1:0] v;
      v      = {NUM_REGS{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/cpu_regfile_sched_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module cpu_scoreboard
   import cpu_regfile_sched_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                set_i,
   input  logic [IDX_W-1:0]    set_idx_i,
   input  logic                clr_i,
   input  logic [IDX_W-1:0]    clr_idx_i,
   input  logic [IDX_W-1:0]    lk1_idx_i,
   input  logic [IDX_W-1:0]    lk2_idx_i,
   input  logic [IDX_W-1:0]    lkd_idx_i,
   output logic                lk1_hit_o,
   output logic                lk2_hit_o,
   output logic                lkd_hit_o,
   output logic [NUM_REGS-1:0] pending_o
);

   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_clr_mask;

   // Set is applied after clear so a same-index collision leaves the bit set.
   always_comb begin
      w_set_mask = {NUM_REGS{1'b0}};
      w_clr_mask = {NUM_REGS{1'b0}};
      if (set_i) begin
         w_set_mask = idx_onehot(set_idx_i);
      end else begin
         w_set_mask = {NUM_REGS{1'b0}};
      end
      if (clr_i) begin
         w_clr_mask = idx_onehot(clr_idx_i);
      end else begin
         w_clr_mask = {NUM_REGS{1'b0}};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pending <= {NUM_REGS{1'b0}};
      end else begin
         r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      end
   end

   assign lk1_hit_o = r_pending[lk1_idx_i];
   assign lk2_hit_o = r_pending[lk2_idx_i];
   assign lkd_hit_o = r_pending[lkd_idx_i];
   assign pending_o = r_pending;

endmodule

// File: rtl/cpu_regfile_sched.sv
// Register-file scheduler: write-port arbitration with debug anti-starvation,
// hazard stall from the scoreboard, and read port 1 lent to debug when decode is idle.
module cpu_regfile_sched
   import cpu_regfile_sched_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                wb_req_i,
   input  logic [IDX_W-1:0]    wb_idx_i,
   input  logic [DATA_W-1:0]   wb_data_i,
   input  logic                ld_req_i,
   input  logic [IDX_W-1:0]    ld_idx_i,
   input  logic [DATA_W-1:0]   ld_data_i,
   input  logic                dbg_req_i,
   input  logic [IDX_W-1:0]    dbg_idx_i,
   input  logic [DATA_W-1:0]   dbg_data_i,
   output logic                wb_gnt_o,
   output logic                ld_gnt_o,
   output logic                dbg_gnt_o,
   input  logic                issue_i,
   input  logic                issue_dest_valid_i,
   input  logic [IDX_W-1:0]    issue_dest_i,
   input  logic                rd_req_i,
   input  logic [IDX_W-1:0]    rd_idx1_i,
   input  logic [IDX_W-1:0]    rd_idx2_i,
   output logic                stall_o,
   output logic                rd_valid_o,
   input  logic                dbg_rd_req_i,
   input  logic [IDX_W-1:0]    dbg_rd_idx_i,
   output logic                dbg_rd_gnt_o,
   output logic                dbg_rd_valid_o,
   output logic                write_enable_o,
   output logic [IDX_W-1:0]    reg_write_index_o,
   output logic [DATA_W-1:0]   value_o,
   output logic                read_enable_o,
   output logic [IDX_W-1:0]    reg_read_index1_o,
   output logic [IDX_W-1:0]    reg_read_index2_o,
   output logic [NUM_REGS-1:0] pending_o
);

   logic [1:0] r_starve_cnt;
   logic       r_rd_valid;
   logic       r_dbg_rd_valid;
   wsel_e      w_wsel;
   logic       w_live;
   logic       w_dbg_pri;
   logic       w_hit1;
   logic       w_hit2;
   logic       w_hitd;
   logic       w_stall;
   logic       w_rd_gnt;
   logic       w_dbg_rd_gnt;
   logic       w_issue_set;
   logic       w_sb_clr;

   assign w_live    = ~rst_i;
   assign w_dbg_pri = (r_starve_cnt == STARVE_LIMIT);

   // Fixed priority wb > ld > dbg, except a starved debug write jumps ahead of load.
   always_comb begin
      w_wsel = WSEL_NONE;
      if (rst_i) begin
         w_wsel = WSEL_NONE;
      end else if (wb_req_i) begin
         w_wsel = WSEL_WB;
      end else if (dbg_req_i && w_dbg_pri) begin
         w_wsel = WSEL_DBG;
      end else if (ld_req_i) begin
         w_wsel = WSEL_LD;
      end else if (dbg_req_i) begin
         w_wsel = WSEL_DBG;
      end else begin
         w_wsel = WSEL_NONE;
      end
   end

   assign wb_gnt_o  = (w_wsel == WSEL_WB);
   assign ld_gnt_o  = (w_wsel == WSEL_LD);
   assign dbg_gnt_o = (w_wsel == WSEL_DBG);

   always_comb begin
      write_enable_o    = 1'b0;
      reg_write_index_o = {IDX_W{1'b0}};
      value_o           = {DATA_W{1'b0}};
      case (w_wsel)
         WSEL_WB: begin
            write_enable_o    = 1'b1;
            reg_write_index_o = wb_idx_i;
            value_o           = wb_data_i;
         end
         WSEL_LD: begin
            write_enable_o    = 1'b1;
            reg_write_index_o = ld_idx_i;
            value_o           = ld_data_i;
         end
         WSEL_DBG: begin
            write_enable_o    = 1'b1;
            reg_write_index_o = dbg_idx_i;
            value_o           = dbg_data_i;
         end
         default: begin
            write_enable_o    = 1'b0;
            reg_write_index_o = {IDX_W{1'b0}};
            value_o           = {DATA_W{1'b0}};
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_starve_cnt <= 2'd0;
      end else if (dbg_req_i && !dbg_gnt_o) begin
         r_starve_cnt <= (r_starve_cnt == 2'd3) ? r_starve_cnt : r_starve_cnt + 2'd1;
      end else begin
         r_starve_cnt <= 2'd0;
      end
   end

   // No bypass: a register written this cycle is still pending, so decode waits.
   assign w_stall      = w_live & rd_req_i & (w_hit1 | w_hit2 | (issue_dest_valid_i & w_hitd));
   assign w_rd_gnt     = w_live & rd_req_i & ~w_stall;
   assign w_dbg_rd_gnt = w_live & dbg_rd_req_i & ~rd_req_i;
   assign w_issue_set  = w_live & issue_i & issue_dest_valid_i & ~w_stall;
   assign w_sb_clr     = wb_gnt_o | ld_gnt_o;

   assign stall_o      = w_stall;
   assign dbg_rd_gnt_o = w_dbg_rd_gnt;

   cpu_scoreboard u_scoreboard (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .set_i     (w_issue_set),
      .set_idx_i (issue_dest_i),
      .clr_i     (w_sb_clr),
      .clr_idx_i (reg_write_index_o),
      .lk1_idx_i (rd_idx1_i),
      .lk2_idx_i (rd_idx2_i),
      .lkd_idx_i (issue_dest_i),
      .lk1_hit_o (w_hit1),
      .lk2_hit_o (w_hit2),
      .lkd_hit_o (w_hitd),
      .pending_o (pending_o)
   );

   always_comb begin
      read_enable_o     = 1'b0;
      reg_read_index1_o = {IDX_W{1'b0}};
      reg_read_index2_o = {IDX_W{1'b0}};
      if (w_rd_gnt) begin
         read_enable_o     = 1'b1;
         reg_read_index1_o = rd_idx1_i;
         reg_read_index2_o = rd_idx2_i;
      end else if (w_dbg_rd_gnt) begin
         read_enable_o     = 1'b1;
         reg_read_index1_o = dbg_rd_idx_i;
         reg_read_index2_o = {IDX_W{1'b0}};
      end else begin
         read_enable_o     = 1'b0;
         reg_read_index1_o = {IDX_W{1'b0}};
         reg_read_index2_o = {IDX_W{1'b0}};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_valid     <= 1'b0;
         r_dbg_rd_valid <= 1'b0;
      end else begin
         r_rd_valid     <= w_rd_gnt;
         r_dbg_rd_valid <= w_dbg_rd_gnt;
      end
   end

   assign rd_valid_o     = r_rd_valid;
   assign dbg_rd_valid_o = r_dbg_rd_valid;

endmodule
